// File: rtl/cursor_pos_ctrl_pkg.sv
// cursor_pkg: shared types and constants for the mouse cursor position path.
//   coord_t   - screen coordinate (sprite origin)
//   delta_t   - signed PS/2 movement field
//   acc_t     - signed delta accumulator at the default width
//   cur_st_t  - per-frame update sequencer states
//   clamp_coord - limits a signed position to [0, hi]
package cursor_pkg;

    localparam int CUR_ACC_W = 12;
    localparam int SCR_H_MAX = 640;
    localparam int SCR_V_MAX = 480;

    typedef logic [10:0]                  coord_t;
    typedef logic signed [8:0]            delta_t;
    typedef logic signed [CUR_ACC_W-1:0]  acc_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        COMMIT = 2'd2
    } cur_st_t;

    function automatic coord_t clamp_coord(input int v, input int hi);
        if (v < 0)
            return '0;
        if (v > hi)
            return coord_t'(hi);
        return coord_t'(v);
    endfunction

endpackage

// File: rtl/cursor_pos_ctrl_sat_accum.sv
// sat_accum: one saturating signed delta accumulator with a snapshot register.
//   clk, reset - clock, asynchronous active-high reset
//   add_en     - add delta this cycle
//   delta      - signed delta, already sign-extended to ACC_W
//   snap_clr   - copy acc into snap and restart acc from zero
//   acc        - running accumulator (saturates at +/-(2^(ACC_W-1)-1))
//   snap       - value captured at the last snap_clr
module sat_accum
    import cursor_pkg::*;
#(
    parameter int ACC_W = CUR_ACC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             add_en,
    input  logic [ACC_W-1:0] delta,
    input  logic             snap_clr,
    output logic [ACC_W-1:0] acc,
    output logic [ACC_W-1:0] snap
);

    localparam int SAT_MAX = (1 << (ACC_W - 1)) - 1;

    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [ACC_W-1:0]        snap_q, snap_d;
    logic signed [ACC_W:0]   base;
    logic signed [ACC_W:0]   addend;
    logic signed [ACC_W:0]   sum;

    // On snap_clr the snapshot takes the pre-add value and a coincident
    // delta lands in the cleared accumulator, so nothing is lost.
    always_comb begin
        base   = snap_clr ? '0 : {acc_q[ACC_W-1], acc_q};
        addend = add_en ? {delta[ACC_W-1], delta} : '0;
        sum    = base + addend;
        if (int'(sum) > SAT_MAX)
            acc_d = {1'b0, {(ACC_W-1){1'b1}}};
        else if (int'(sum) < -SAT_MAX)
            acc_d = {1'b1, {(ACC_W-2){1'b0}}, 1'b1};
        else
            acc_d = sum[ACC_W-1:0];
        snap_d = snap_clr ? acc_q : snap_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            snap_q <= '0;
        end else begin
            acc_q  <= acc_d;
            snap_q <= snap_d;
        end
    end

    assign acc  = acc_q;
    assign snap = snap_q;

endmodule

// File: rtl/cursor_pos_ctrl.sv
// cursor_pos_ctrl: turns PS/2 mouse packets into the cursor sprite origin.
// Deltas accumulate between frames and are applied once per frame, starting
// at frame_start, so the origin never moves mid-scan.
//   clk, reset         - clock, asynchronous active-high reset
//   mouse_valid        - packet strobe; dx, dy, ovf_x, ovf_y, btn valid
//   dx, dy             - signed movement (dy positive = up)
//   ovf_x, ovf_y       - packet overflow flags; flagged axis is discarded
//   btn                - {mid, right, left}
//   frame_start        - start-of-vblank strobe
//   x0, y0             - sprite origin, clamped to the visible area
//   btn_q              - registered button state
//   click              - one-cycle pulse on left-button press
//   pos_upd            - one-cycle pulse in the cycle x0/y0 take new values
module cursor_pos_ctrl
    import cursor_pkg::*;
#(
    parameter int H_MAX  = SCR_H_MAX,
    parameter int V_MAX  = SCR_V_MAX,
    parameter int X_INIT = 320,
    parameter int Y_INIT = 240,
    parameter int ACC_W  = CUR_ACC_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mouse_valid,
    input  logic [8:0]  dx,
    input  logic [8:0]  dy,
    input  logic        ovf_x,
    input  logic        ovf_y,
    input  logic [2:0]  btn,
    input  logic        frame_start,
    output logic [10:0] x0,
    output logic [10:0] y0,
    output logic [2:0]  btn_q,
    output logic        click,
    output logic        pos_upd
);

    cur_st_t                state_q, state_d;
    coord_t                 x0_q, x0_d, y0_q, y0_d;
    logic signed [ACC_W:0]  sum_x_q, sum_x_d, sum_y_q, sum_y_d;
    logic [2:0]             btn_d;
    logic                   click_q, click_d;
    logic                   pos_upd_q, pos_upd_d;

    delta_t                 dx_s, dy_s;
    logic [ACC_W-1:0]       dx_ext, dy_neg;
    logic [ACC_W-1:0]       acc_x, acc_y, snap_x, snap_y;
    logic                   snap_clr;

    // Screen Y grows downward, so the Y accumulator is fed -dy.
    always_comb begin
        dx_s   = dx;
        dy_s   = dy;
        dx_ext = {{(ACC_W-9){dx_s[8]}}, dx_s};
        dy_neg = -{{(ACC_W-9){dy_s[8]}}, dy_s};
    end

    assign snap_clr = (state_q == IDLE) && frame_start;

    sat_accum #(.ACC_W(ACC_W)) u_acc_x (
        .clk      (clk),
        .reset    (reset),
        .add_en   (mouse_valid && !ovf_x),
        .delta    (dx_ext),
        .snap_clr (snap_clr),
        .acc      (acc_x),
        .snap     (snap_x)
    );

    sat_accum #(.ACC_W(ACC_W)) u_acc_y (
        .clk      (clk),
        .reset    (reset),
        .add_en   (mouse_valid && !ovf_y),
        .delta    (dy_neg),
        .snap_clr (snap_clr),
        .acc      (acc_y),
        .snap     (snap_y)
    );

    always_comb begin
        state_d   = state_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        sum_x_d   = sum_x_q;
        sum_y_d   = sum_y_q;
        pos_upd_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start)
                    state_d = CALC;
            end
            CALC: begin
                // Origin is zero-extended, snapshot sign-extended, one spare bit.
                sum_x_d = $signed({{(ACC_W-10){1'b0}}, x0_q}) + $signed({snap_x[ACC_W-1], snap_x});
                sum_y_d = $signed({{(ACC_W-10){1'b0}}, y0_q}) + $signed({snap_y[ACC_W-1], snap_y});
                state_d = COMMIT;
            end
            COMMIT: begin
                x0_d      = clamp_coord(int'(sum_x_q), H_MAX - 1);
                y0_d      = clamp_coord(int'(sum_y_q), V_MAX - 1);
                pos_upd_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        btn_d   = mouse_valid ? btn : btn_q;
        click_d = mouse_valid && btn[0] && !btn_q[0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            x0_q      <= coord_t'(X_INIT);
            y0_q      <= coord_t'(Y_INIT);
            sum_x_q   <= '0;
            sum_y_q   <= '0;
            btn_q     <= '0;
            click_q   <= 1'b0;
            pos_upd_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            sum_x_q   <= sum_x_d;
            sum_y_q   <= sum_y_d;
            btn_q     <= btn_d;
            click_q   <= click_d;
            pos_upd_q <= pos_upd_d;
        end
    end

    assign x0      = x0_q;
    assign y0      = y0_q;
    assign click   = click_q;
    assign pos_upd = pos_upd_q;

endmodule

// File: tb/tb_cursor_pos_ctrl.sv
module tb_cursor_pos_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        mouse_valid;
    logic [8:0]  dx, dy;
    logic        ovf_x, ovf_y;
    logic [2:0]  btn;
    logic        frame_start;
    logic [10:0] x0, y0;
    logic [2:0]  btn_q;
    logic        click;
    logic        pos_upd;

    cursor_pos_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .mouse_valid (mouse_valid),
        .dx          (dx),
        .dy          (dy),
        .ovf_x       (ovf_x),
        .ovf_y       (ovf_y),
        .btn         (btn),
        .frame_start (frame_start),
        .x0          (x0),
        .y0          (y0),
        .btn_q       (btn_q),
        .click       (click),
        .pos_upd     (pos_upd)
    );

    always #5 clk = ~clk;

    typedef struct { int x; int y; } exp_pos_t;
    exp_pos_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_clicks = 0;

    // Reference model state
    int         m_x = 320, m_y = 240;
    int         m_ax = 0, m_ay = 0;
    logic [2:0] m_btn = 3'b000;

    function automatic int sat(input int v);
        if (v > 2047) return 2047;
        if (v < -2047) return -2047;
        return v;
    endfunction

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_pkt(input int dxv, input int dyv, input bit ox, input bit oy,
                             input logic [2:0] b, output bit exp_click);
        exp_click = b[0] & ~m_btn[0];
        if (!ox) m_ax = sat(m_ax + dxv);
        if (!oy) m_ay = sat(m_ay - dyv);
        m_btn = b;
    endtask

    task automatic drive_fields(input int dxv, input int dyv, input bit ox, input bit oy,
                                input logic [2:0] b);
        mouse_valid = 1'b1;
        dx    = 9'(dxv);
        dy    = 9'(dyv);
        ovf_x = ox;
        ovf_y = oy;
        btn   = b;
    endtask

    task automatic send_pkt(input int dxv, input int dyv, input bit ox, input bit oy,
                            input logic [2:0] b);
        bit ec;
        @(negedge clk);
        drive_fields(dxv, dyv, ox, oy, b);
        model_pkt(dxv, dyv, ox, oy, b, ec);
        @(negedge clk);
        mouse_valid = 1'b0;
        check("click", 32'(click), 32'(ec));
        check("btn_q", 32'(btn_q), 32'(b));
        if (click === 1'b1) n_clicks++;
        @(negedge clk);
        check("click_width", 32'(click), 32'd0);
    endtask

    task automatic run_frame(input bit with_pkt, input int pdx, input bit extra_fs);
        exp_pos_t e;
        bit ec;
        int lat;
        @(negedge clk);
        frame_start = 1'b1;
        e.x = clampi(m_x + m_ax, 639);
        e.y = clampi(m_y + m_ay, 479);
        m_ax = 0;
        m_ay = 0;
        m_x  = e.x;
        m_y  = e.y;
        sb_q.push_back(e);
        if (with_pkt) begin
            drive_fields(pdx, 0, 1'b0, 1'b0, m_btn);
            model_pkt(pdx, 0, 1'b0, 1'b0, m_btn, ec);
        end
        @(negedge clk);
        mouse_valid = 1'b0;
        frame_start = extra_fs;
        check("pos_upd_early", 32'(pos_upd), 32'd0);
        lat = 0;
        while (pos_upd !== 1'b1 && lat < 8) begin
            @(negedge clk);
            frame_start = 1'b0;
            lat++;
        end
        frame_start = 1'b0;
        check("latency", 32'(lat), 32'd2);
        if (pos_upd === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("sb_empty", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("x0", 32'(x0), 32'(e.x));
                check("y0", 32'(y0), 32'(e.y));
            end
        end
        @(negedge clk);
        check("pos_upd_width", 32'(pos_upd), 32'd0);
        @(negedge clk);
        check("pos_upd_extra", 32'(pos_upd), 32'd0);
    endtask

    task automatic move_to(input int tx, input int ty);
        int rx, ry, step;
        rx = tx - m_x;
        ry = -(ty - m_y);
        while (rx != 0) begin
            step = (rx > 200) ? 200 : ((rx < -200) ? -200 : rx);
            send_pkt(step, 0, 1'b0, 1'b0, m_btn);
            rx -= step;
        end
        while (ry != 0) begin
            step = (ry > 200) ? 200 : ((ry < -200) ? -200 : ry);
            send_pkt(0, step, 1'b0, 1'b0, m_btn);
            ry -= step;
        end
        run_frame(1'b0, 0, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        mouse_valid = 1'b0;
        dx = '0; dy = '0; ovf_x = 1'b0; ovf_y = 1'b0;
        btn = '0;
        frame_start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_x0", 32'(x0), 32'd320);
        check("rst_y0", 32'(y0), 32'd240);
        check("rst_btn_q", 32'(btn_q), 32'd0);
        check("rst_click", 32'(click), 32'd0);
        check("rst_pos_upd", 32'(pos_upd), 32'd0);
        reset = 1'b0;

        // Accumulation: 320+12=332, 240-4=236
        send_pkt(10, 4, 1'b0, 1'b0, 3'b000);
        send_pkt(5, 0, 1'b0, 1'b0, 3'b000);
        send_pkt(-3, 0, 1'b0, 1'b0, 3'b000);
        run_frame(1'b0, 0, 1'b0);

        // Zero-delta frame still pulses pos_upd
        run_frame(1'b0, 0, 1'b0);

        // Clamping
        move_to(5, 240);
        send_pkt(-20, 0, 1'b0, 1'b0, m_btn);
        run_frame(1'b0, 0, 1'b0);
        move_to(630, 470);
        send_pkt(50, -40, 1'b0, 1'b0, m_btn);
        run_frame(1'b0, 0, 1'b0);
        send_pkt(0, 255, 1'b0, 1'b0, m_btn);
        send_pkt(0, 255, 1'b0, 1'b0, m_btn);
        run_frame(1'b0, 0, 1'b0);

        // Accumulator saturation, observed through the clamp
        for (int i = 0; i < 10; i++)
            send_pkt(-255, 0, 1'b0, 1'b0, m_btn);
        for (int i = 0; i < 3; i++)
            send_pkt(255, 0, 1'b0, 1'b0, m_btn);
        run_frame(1'b0, 0, 1'b0);

        // Overflow flags
        move_to(300, 200);
        send_pkt(100, -8, 1'b1, 1'b0, m_btn);
        run_frame(1'b0, 0, 1'b0);

        // Coincident packet and frame_start, plus frame_start during CALC
        run_frame(1'b1, 7, 1'b1);
        run_frame(1'b0, 0, 1'b0);

        // Buttons
        n_clicks = 0;
        send_pkt(0, 0, 1'b0, 1'b0, 3'b000);
        send_pkt(0, 0, 1'b0, 1'b0, 3'b001);
        send_pkt(0, 0, 1'b0, 1'b0, 3'b001);
        send_pkt(0, 0, 1'b0, 1'b0, 3'b000);
        send_pkt(0, 0, 1'b0, 1'b0, 3'b001);
        check("click_count", 32'(n_clicks), 32'd2);
        send_pkt(0, 0, 1'b0, 1'b0, 3'b110);

        // Reset mid-frame with a pending delta
        send_pkt(30, 10, 1'b0, 1'b0, 3'b011);
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_x0", 32'(x0), 32'd320);
        check("mid_rst_y0", 32'(y0), 32'd240);
        check("mid_rst_btn_q", 32'(btn_q), 32'd0);
        check("mid_rst_click", 32'(click), 32'd0);
        check("mid_rst_pos_upd", 32'(pos_upd), 32'd0);
        m_x = 320; m_y = 240; m_ax = 0; m_ay = 0; m_btn = 3'b000;
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_pos_upd", 32'(pos_upd), 32'd0);
        end
        run_frame(1'b0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
